// File: rtl/uart_pkg.sv
// Shared UART definitions: frame decoder state encoding, default start-of-frame
// marker and the bit-period helper used to size the inter-byte timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHKB    = 3'd4,
    HOLD    = 3'd5
  } frame_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Number of clk cycles in one UART bit time.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write,
// registered read (one cycle of latency from rd_addr_i to rd_data_o).
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Write port: payload bytes land here while a frame is being assembled.
  // NOTE: the array has no reset so synthesis can map it onto RAM primitives;
  // only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: registered so o_rd_data is 0 out of reset and 1 cycle behind the address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SOF/CMD/LEN/payload/CHK frames from UART byte strobes, checks the
// XOR checksum, holds one good frame for the command layer and flags bad,
// oversized, stalled and overrun traffic with single-cycle pulses.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int         FPGA_clk_freq = 50000000,
  parameter int         baudrate      = 115200,
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
  parameter int         TIMEOUT_BITS  = 30,
  localparam int        LW            = $clog2(MAX_LEN + 1),
  localparam int        AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rx_dv,
  input  logic [7:0]    i_rx_byte,
  output logic          o_frm_valid,
  input  logic          i_frm_ready,
  output logic [7:0]    o_frm_cmd,
  output logic [LW-1:0] o_frm_len,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_err_chk,
  output logic          o_err_len,
  output logic          o_err_tmo,
  output logic          o_overrun
);

  localparam int TMO_CLKS = TIMEOUT_BITS * clks_per_bit(FPGA_clk_freq, baudrate);
  localparam int CW       = (TMO_CLKS > 1) ? $clog2(TMO_CLKS) : 1;

  frame_state_t  state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frm_valid_q, frm_valid_d;
  logic [7:0]    frm_cmd_q, frm_cmd_d;
  logic [LW-1:0] frm_len_q, frm_len_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_tmo_q, err_tmo_d;
  logic          overrun_q, overrun_d;
  logic          buf_wr_en;

  logic counting;
  logic tmo_hit;
  logic rx;

  // The timeout only runs while a frame is partially received; when it fires
  // it takes priority and any byte strobe in the same cycle is discarded.
  assign counting = (state_q == CMD) || (state_q == LEN) ||
                    (state_q == PAYLOAD) || (state_q == CHKB);
  assign tmo_hit  = counting && (cnt_q == CW'(TMO_CLKS - 1));
  assign rx       = i_rx_dv && !tmo_hit;

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame parsing, with timeout abort and illegal-state recovery.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned and
    // no latch is inferred.
    state_d = state_q;
    if (tmo_hit) begin
      state_d = HUNT;
    end else begin
      unique case (state_q)
        HUNT:    if (rx && (i_rx_byte == SOF_BYTE)) state_d = CMD;
        CMD:     if (rx) state_d = LEN;
        LEN: begin
          if (rx) begin
            if (i_rx_byte > 8'(MAX_LEN))  state_d = HUNT;
            else if (i_rx_byte == 8'h00)  state_d = CHKB;
            else                          state_d = PAYLOAD;
          end
        end
        PAYLOAD: if (rx && (idx_q == len_q - LW'(1))) state_d = CHKB;
        CHKB: begin
          if (rx) state_d = (i_rx_byte == chk_q) ? HOLD : HUNT;
        end
        HOLD:    if (i_frm_ready) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath next values: capture fields, accumulate checksum, raise flag pulses.
  always_comb begin
    cmd_d       = cmd_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    frm_valid_d = frm_valid_q;
    frm_cmd_d   = frm_cmd_q;
    frm_len_d   = frm_len_q;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_tmo_d   = tmo_hit;
    overrun_d   = 1'b0;
    buf_wr_en   = 1'b0;
    cnt_d       = (counting && !i_rx_dv && !tmo_hit) ? cnt_q + CW'(1) : '0;

    unique case (state_q)
      CMD: begin
        if (rx) begin
          cmd_d = i_rx_byte;
          chk_d = i_rx_byte;
        end
      end
      LEN: begin
        if (rx) begin
          if (i_rx_byte > 8'(MAX_LEN)) begin
            err_len_d = 1'b1;
          end else begin
            len_d = i_rx_byte[LW-1:0];
            chk_d = chk_q ^ i_rx_byte;
            idx_d = '0;
          end
        end
      end
      PAYLOAD: begin
        if (rx) begin
          buf_wr_en = 1'b1;
          chk_d     = chk_q ^ i_rx_byte;
          idx_d     = idx_q + LW'(1);
        end
      end
      CHKB: begin
        if (rx) begin
          if (i_rx_byte == chk_q) begin
            frm_valid_d = 1'b1;
            frm_cmd_d   = cmd_q;
            frm_len_d   = len_q;
          end else begin
            err_chk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        overrun_d = i_rx_dv;
        if (i_frm_ready) frm_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q       <= 8'h00;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= 8'h00;
      cnt_q       <= '0;
      frm_valid_q <= 1'b0;
      frm_cmd_q   <= 8'h00;
      frm_len_q   <= '0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      frm_valid_q <= frm_valid_d;
      frm_cmd_q   <= frm_cmd_d;
      frm_len_q   <= frm_len_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
      overrun_q   <= overrun_d;
    end
  end

  frame_buf #(
    .DEPTH(MAX_LEN),
    .AW   (AW)
  ) u_frame_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (buf_wr_en),
    .wr_addr_i(idx_q[AW-1:0]),
    .wr_data_i(i_rx_byte),
    .rd_addr_i(i_rd_addr),
    .rd_data_o(o_rd_data)
  );

  assign o_frm_valid = frm_valid_q;
  assign o_frm_cmd   = frm_cmd_q;
  assign o_frm_len   = frm_len_q;
  assign o_err_chk   = err_chk_q;
  assign o_err_len   = err_len_q;
  assign o_err_tmo   = err_tmo_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder. Timing is scaled down so that
// TMO_CLKS = 3 bits * (1000/100) clks = 30 cycles; MAX_LEN = 16.
module tb_uart_frame_decoder;

  localparam int TMO = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_frm_valid;
  logic       i_frm_ready;
  logic [7:0] o_frm_cmd;
  logic [4:0] o_frm_len;
  logic [3:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       o_err_chk;
  logic       o_err_len;
  logic       o_err_tmo;
  logic       o_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse counters and width monitor, sampled mid-cycle.
  int cnt_chk = 0, cnt_len = 0, cnt_tmo = 0, cnt_ovr = 0, wide = 0;
  logic [3:0] prev_p = 4'b0000;

  uart_frame_decoder #(
    .FPGA_clk_freq(1000),
    .baudrate     (100),
    .MAX_LEN      (16),
    .SOF_BYTE     (8'hA5),
    .TIMEOUT_BITS (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx_dv    (i_rx_dv),
    .i_rx_byte  (i_rx_byte),
    .o_frm_valid(o_frm_valid),
    .i_frm_ready(i_frm_ready),
    .o_frm_cmd  (o_frm_cmd),
    .o_frm_len  (o_frm_len),
    .i_rd_addr  (i_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_err_chk  (o_err_chk),
    .o_err_len  (o_err_len),
    .o_err_tmo  (o_err_tmo),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [3:0] p;
    p = {o_err_chk === 1'b1, o_err_len === 1'b1, o_err_tmo === 1'b1, o_overrun === 1'b1};
    if (p[3]) cnt_chk++;
    if (p[2]) cnt_len++;
    if (p[1]) cnt_tmo++;
    if (p[0]) cnt_ovr++;
    if ((p & prev_p) != 4'b0000) wide++;
    prev_p = p;
  end

  // One strobe followed by one idle cycle; returns 1 time unit after a posedge.
  task automatic send_byte(input logic [7:0] b);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(posedge clk); #1;
    i_rx_dv   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame1();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
  endtask

  task automatic send_frame2();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
  endtask

  task automatic release_frame();
    i_frm_ready = 1'b1;
    @(posedge clk); #1;
    i_frm_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_frm_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_frm_valid); else n_pass++;
    n_checks++; if (o_frm_cmd !== 8'h00) $display("FAIL reset_cmd got=%h exp=00", o_frm_cmd); else n_pass++;
    n_checks++; if (o_frm_len !== 5'd0) $display("FAIL reset_len got=%0d exp=0", o_frm_len); else n_pass++;
    n_checks++; if (o_rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", o_rd_data); else n_pass++;
    n_checks++;
    if ({o_err_chk, o_err_len, o_err_tmo, o_overrun} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {o_err_chk, o_err_len, o_err_tmo, o_overrun});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp_pl [3];
    exp_pl = '{8'h11, 8'h22, 8'h33};
    send_frame1();
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", o_frm_valid); else n_pass++;
    n_checks++; if (o_frm_cmd !== 8'h10) $display("FAIL basic_cmd got=%h exp=10", o_frm_cmd); else n_pass++;
    n_checks++; if (o_frm_len !== 5'd3) $display("FAIL basic_len got=%0d exp=3", o_frm_len); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      i_rd_addr = 4'(i);
      @(posedge clk); #1;
      n_checks++;
      if (o_rd_data !== exp_pl[i]) $display("FAIL basic_rd[%0d] got=%h exp=%h", i, o_rd_data, exp_pl[i]);
      else n_pass++;
    end
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL basic_hold got=%b exp=1", o_frm_valid); else n_pass++;
    release_frame();
    n_checks++; if (o_frm_valid !== 1'b0) $display("FAIL basic_release got=%b exp=0", o_frm_valid); else n_pass++;
  endtask

  task automatic test_empty_payload();
    send_frame2();
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL empty_valid got=%b exp=1", o_frm_valid); else n_pass++;
    n_checks++; if (o_frm_cmd !== 8'h20) $display("FAIL empty_cmd got=%h exp=20", o_frm_cmd); else n_pass++;
    n_checks++; if (o_frm_len !== 5'd0) $display("FAIL empty_len got=%0d exp=0", o_frm_len); else n_pass++;
    release_frame();
  endtask

  task automatic test_bad_checksum();
    int c0;
    c0 = cnt_chk;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h00);
    n_checks++; if (cnt_chk - c0 !== 1) $display("FAIL badchk_pulses got=%0d exp=1", cnt_chk - c0); else n_pass++;
    n_checks++; if (o_frm_valid !== 1'b0) $display("FAIL badchk_valid got=%b exp=0", o_frm_valid); else n_pass++;
    send_frame1();
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL badchk_recover got=%b exp=1", o_frm_valid); else n_pass++;
    release_frame();
  endtask

  task automatic test_len_error();
    int c0;
    c0 = cnt_len;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
    n_checks++; if (cnt_len - c0 !== 1) $display("FAIL len_pulses got=%0d exp=1", cnt_len - c0); else n_pass++;
    n_checks++; if (o_frm_valid !== 1'b0) $display("FAIL len_valid got=%b exp=0", o_frm_valid); else n_pass++;
    send_byte(8'h55);
    send_frame2();
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL len_recover_valid got=%b exp=1", o_frm_valid); else n_pass++;
    n_checks++; if (o_frm_cmd !== 8'h20) $display("FAIL len_recover_cmd got=%h exp=20", o_frm_cmd); else n_pass++;
    release_frame();
  endtask

  task automatic test_max_len();
    // CMD 30, LEN 16, payload 00..0F (XOR = 00) -> CHK = 30^10 = 20.
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h20);
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL maxlen_valid got=%b exp=1", o_frm_valid); else n_pass++;
    n_checks++; if (o_frm_len !== 5'd16) $display("FAIL maxlen_len got=%0d exp=16", o_frm_len); else n_pass++;
    i_rd_addr = 4'd15;
    @(posedge clk); #1;
    n_checks++; if (o_rd_data !== 8'h0F) $display("FAIL maxlen_rd15 got=%h exp=0f", o_rd_data); else n_pass++;
    release_frame();
  endtask

  task automatic test_timeout();
    int c0, k_hit;
    c0 = cnt_tmo;
    k_hit = -1;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    i_rx_dv = 1'b1; i_rx_byte = 8'h11;
    @(posedge clk); #1;
    i_rx_dv = 1'b0;
    for (int k = 1; k <= TMO + 10; k++) begin
      @(posedge clk); #1;
      if (o_err_tmo === 1'b1 && k_hit < 0) k_hit = k;
    end
    n_checks++; if (k_hit !== TMO) $display("FAIL tmo_latency got=%0d exp=%0d", k_hit, TMO); else n_pass++;
    n_checks++; if (cnt_tmo - c0 !== 1) $display("FAIL tmo_pulses got=%0d exp=1", cnt_tmo - c0); else n_pass++;
    send_frame2();
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL tmo_recover got=%b exp=1", o_frm_valid); else n_pass++;
    release_frame();
  endtask

  task automatic test_overrun();
    int c0;
    c0 = cnt_ovr;
    send_frame1();
    send_byte(8'hA5);
    send_byte(8'h44);
    n_checks++; if (cnt_ovr - c0 !== 2) $display("FAIL ovr_pulses got=%0d exp=2", cnt_ovr - c0); else n_pass++;
    n_checks++; if (o_frm_cmd !== 8'h10) $display("FAIL ovr_cmd got=%h exp=10", o_frm_cmd); else n_pass++;
    n_checks++; if (o_frm_len !== 5'd3) $display("FAIL ovr_len got=%0d exp=3", o_frm_len); else n_pass++;
    i_rd_addr = 4'd1;
    @(posedge clk); #1;
    n_checks++; if (o_rd_data !== 8'h22) $display("FAIL ovr_payload got=%h exp=22", o_rd_data); else n_pass++;
    // Byte on the release cycle is still dropped.
    i_frm_ready = 1'b1; i_rx_dv = 1'b1; i_rx_byte = 8'hA5;
    @(posedge clk); #1;
    i_frm_ready = 1'b0; i_rx_dv = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (cnt_ovr - c0 !== 3) $display("FAIL ovr_release_pulse got=%0d exp=3", cnt_ovr - c0); else n_pass++;
    n_checks++; if (o_frm_valid !== 1'b0) $display("FAIL ovr_release_valid got=%b exp=0", o_frm_valid); else n_pass++;
    // The A5 was dropped, so this CMD byte must not start a frame.
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
    n_checks++; if (o_frm_valid !== 1'b0) $display("FAIL ovr_dropped_sof got=%b exp=0", o_frm_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    e0 = cnt_chk + cnt_len + cnt_tmo + cnt_ovr;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_frm_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", o_frm_valid); else n_pass++;
    n_checks++; if (o_frm_cmd !== 8'h00) $display("FAIL rstmid_cmd got=%h exp=00", o_frm_cmd); else n_pass++;
    n_checks++; if (o_rd_data !== 8'h00) $display("FAIL rstmid_rd got=%h exp=00", o_rd_data); else n_pass++;
    rst_n = 1'b1;
    repeat (TMO + 5) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_chk + cnt_len + cnt_tmo + cnt_ovr - e0 !== 0)
      $display("FAIL rstmid_no_err got=%0d exp=0", cnt_chk + cnt_len + cnt_tmo + cnt_ovr - e0);
    else n_pass++;
    send_frame1();
    n_checks++; if (o_frm_valid !== 1'b1) $display("FAIL rstmid_recover got=%b exp=1", o_frm_valid); else n_pass++;
    release_frame();
  endtask

  initial begin
    rst_n       = 1'b0;
    i_rx_dv     = 1'b0;
    i_rx_byte   = 8'h00;
    i_frm_ready = 1'b0;
    i_rd_addr   = 4'd0;
    test_reset();
    test_basic_frame();
    test_empty_payload();
    test_bad_checksum();
    test_len_error();
    test_max_len();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    n_checks++; if (wide !== 0) $display("FAIL pulse_width got=%0d exp=0", wide); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
